// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: instruction-bus bit layout, idle instruction and controller states
package core_ctrl_pkg;
    localparam int inst_w = 34;
    localparam int addr_w = 11;
    localparam int b_acc = 33;
    localparam int b_cen_p = 32;
    localparam int b_wen_p = 31;
    localparam int b_a_p = 20;
    localparam int b_cen_x = 19;
    localparam int b_wen_x = 18;
    localparam int b_a_x = 7;
    localparam int b_ofifo_rd = 6;
    localparam int b_l0_rd = 3;
    localparam int b_l0_wr = 2;
    localparam int b_execute = 1;
    localparam int b_load = 0;
    localparam logic [inst_w-1:0] idle_inst = 34'h1_800C_0000;
    typedef enum logic [2:0] {
        st_idle,
        st_w_l0,
        st_w_load,
        st_x_l0,
        st_exec,
        st_drain,
        st_acc
    } state_t;
endpackage

// File: rtl/core_ctrl_if.sv
// core_ctrl_if: job handshake and core instruction bus between host and controller
interface core_ctrl_if;
    import core_ctrl_pkg::*;
    logic start;
    logic ofifo_valid;
    logic [inst_w-1:0] inst;
    logic busy;
    logic acc_clr;
    logic out_valid;
    logic done;
    modport master (output start, ofifo_valid, input inst, busy, acc_clr, out_valid, done);
    modport slave (input start, ofifo_valid, output inst, busy, acc_clr, out_valid, done);
endinterface

// File: rtl/core_ctrl_addr.sv
// core_ctrl_addr: psum address holding kernel tap k's partial sum for output pixel o
module core_ctrl_addr
    import core_ctrl_pkg::*;
#(
    parameter int len_nij = 36,
    parameter int ow = 4,
    parameter int kw = 4
) (
    input  logic [ow-1:0] o,
    input  logic [kw-1:0] k,
    output logic [addr_w-1:0] a
);
    assign a = addr_w'(int'(k) * len_nij + (int'(o) / 4 + int'(k) / 3) * 6 + int'(o) % 4 + int'(k) % 3);
endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: phase sequencer issuing the core instruction stream for one convolution job
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int col = 8,
    parameter int row = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int len_onij = 16,
    parameter int gap = 4
) (
    input logic clk,
    input logic reset,
    core_ctrl_if.slave bus
);
    localparam int cw = $clog2(len_nij + row + col + gap + 1);
    localparam int kw = $clog2(len_kij);
    localparam int ow = $clog2(len_onij);
    localparam logic [cw-1:0] c_rd_hi = cw'(len_kij);
    localparam logic [cw-1:0] c_acc_hi = cw'(len_kij + 1);
    localparam logic [cw-1:0] c_ov = cw'(len_kij + 2);
    localparam logic [cw-1:0] c_done = cw'(len_kij + 3);

    state_t st, st_n, cs;
    logic [cw-1:0] cnt, cnt_n, plen, last;
    logic [kw-1:0] kij, kij_n;
    logic [ow-1:0] o, o_n;
    logic [addr_w-1:0] acc_addr;
    logic [inst_w-1:0] inst_n;
    logic act, clr_n, ov_n, done_n;

    core_ctrl_addr #(.len_nij(len_nij), .ow(ow), .kw(kw)) u_addr (
        .o(o),
        .k(kw'(cnt - 1'b1)),
        .a(acc_addr)
    );

    // a start seen in IDLE issues the first W_L0 step on this same edge; every phase ends with gap idle steps
    always_comb begin
        cs = (st == st_idle && bus.start) ? st_w_l0 : st;
        plen = (cs == st_w_l0 || cs == st_w_load) ? cw'(col) : (cs == st_exec) ? cw'(len_nij + row + col) : cw'(len_nij);
        last = plen + cw'(gap - 1);
        act = cnt < plen;
        inst_n = idle_inst;
        clr_n = 1'b0;
        ov_n = 1'b0;
        done_n = 1'b0;
        st_n = cs;
        cnt_n = cnt + 1'b1;
        kij_n = kij;
        o_n = o;
        case (cs)
            st_idle: cnt_n = '0;
            st_w_l0: if (act) begin
                inst_n[b_cen_x] = 1'b0;
                inst_n[b_l0_wr] = 1'b1;
                inst_n[b_a_x +: addr_w] = addr_w'(1024 + int'(kij) * col + int'(cnt));
            end
            st_w_load: if (act) begin
                inst_n[b_l0_rd] = 1'b1;
                inst_n[b_load] = 1'b1;
            end
            st_x_l0: if (act) begin
                inst_n[b_cen_x] = 1'b0;
                inst_n[b_l0_wr] = 1'b1;
                inst_n[b_a_x +: addr_w] = addr_w'(cnt);
            end
            st_exec: if (act) begin
                inst_n[b_l0_rd] = 1'b1;
                inst_n[b_execute] = 1'b1;
            end
            st_drain: if (act && bus.ofifo_valid) begin
                inst_n[b_ofifo_rd] = 1'b1;
                inst_n[b_cen_p] = 1'b0;
                inst_n[b_wen_p] = 1'b0;
                inst_n[b_a_p +: addr_w] = addr_w'(int'(kij) * len_nij + int'(cnt));
            end else if (act) cnt_n = cnt;
            st_acc: begin
                clr_n = cnt == '0;
                if (cnt != '0 && cnt <= c_rd_hi) begin
                    inst_n[b_cen_p] = 1'b0;
                    inst_n[b_a_p +: addr_w] = acc_addr;
                end
                inst_n[b_acc] = cnt > cw'(1) && cnt <= c_acc_hi;
                ov_n = cnt == c_ov;
                done_n = cnt == c_done;
                if (ov_n && o != ow'(len_onij - 1)) begin
                    o_n = o + 1'b1;
                    cnt_n = '0;
                end
                if (done_n) begin
                    st_n = st_idle;
                    cnt_n = '0;
                    kij_n = '0;
                    o_n = '0;
                end
            end
            default: ;
        endcase
        if (cs != st_idle && cs != st_acc && cnt == last) begin
            cnt_n = '0;
            st_n = (cs == st_w_l0) ? st_w_load : (cs == st_w_load) ? st_x_l0 : (cs == st_x_l0) ? st_exec :
                   (cs == st_exec) ? st_drain : (kij == kw'(len_kij - 1)) ? st_acc : st_w_l0;
            if (cs == st_drain && kij != kw'(len_kij - 1)) kij_n = kij + 1'b1;
        end
    end

    // state, counters and every output are registered; reset parks the bus at its idle value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= st_idle;
            cnt <= '0;
            kij <= '0;
            o <= '0;
            bus.inst <= idle_inst;
            bus.busy <= 1'b0;
            bus.acc_clr <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            st <= st_n;
            cnt <= cnt_n;
            kij <= kij_n;
            o <= o_n;
            bus.inst <= inst_n;
            bus.busy <= st_n != st_idle;
            bus.acc_clr <= clr_n;
            bus.out_valid <= ov_n;
            bus.done <= done_n;
        end
    end
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: randomized jobs of core_ctrl checked against a per-job expected step list
module tb_core_ctrl;
    localparam int col = 8, row = 8, n_kij = 9, n_nij = 36, n_onij = 16, n_gap = 4;
    localparam logic [33:0] idle = 34'h1_800C_0000;
    typedef struct {
        logic [33:0] inst;
        bit clr;
        bit ov;
        bit dn;
        bit wr;
    } item_t;

    logic clk = 0;
    logic rst_n = 0;
    core_ctrl_if bus();
    core_ctrl #(.col(col), .row(row), .len_kij(n_kij), .len_nij(n_nij), .len_onij(n_onij), .gap(n_gap)) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    item_t q[$];
    logic [33:0] e_inst = idle;
    bit e_busy = 0, e_clr = 0, e_ov = 0, e_dn = 0;
    int wr_q[$], rd_q[$], xw_q[$];
    int ov_cnt = 0, dn_cnt = 0;

    task automatic chk(input string n, input logic [33:0] a, input logic [33:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [33:0] ins(input bit acc, input bit cenp, input bit wenp, input int ap,
                                        input bit cenx, input int ax, input logic [6:0] lo);
        return {acc, cenp, wenp, 11'(ap), cenx, 1'b1, 11'(ax), lo};
    endfunction

    function automatic void push(input logic [33:0] i, input bit c, input bit v, input bit d, input bit w);
        q.push_back('{i, c, v, d, w});
    endfunction

    function automatic void pad();
        for (int g = 0; g < n_gap; g++) push(idle, 0, 0, 0, 0);
    endfunction

    // psum row k*36 holds tap k; output (oy,ox) with tap (ky,kx) reads input pixel (oy+ky)*6+(ox+kx)
    function automatic int pix(input int o, input int k);
        return k * n_nij + (o / 4 + k / 3) * 6 + (o % 4 + k % 3);
    endfunction

    function automatic void build();
        q.delete();
        for (int kij = 0; kij < n_kij; kij++) begin
            for (int i = 0; i < col; i++) push(ins(0, 1, 1, 0, 0, 1024 + kij * col + i, 7'b0000100), 0, 0, 0, 0);
            pad();
            for (int i = 0; i < col; i++) push(ins(0, 1, 1, 0, 1, 0, 7'b0001001), 0, 0, 0, 0);
            pad();
            for (int i = 0; i < n_nij; i++) push(ins(0, 1, 1, 0, 0, i, 7'b0000100), 0, 0, 0, 0);
            pad();
            for (int i = 0; i < n_nij + row + col; i++) push(ins(0, 1, 1, 0, 1, 0, 7'b0001010), 0, 0, 0, 0);
            pad();
            for (int i = 0; i < n_nij; i++) push(ins(0, 0, 0, kij * n_nij + i, 1, 0, 7'b1000000), 0, 0, 0, 1);
            pad();
        end
        for (int o = 0; o < n_onij; o++) begin
            push(idle, 1, 0, 0, 0);
            for (int k = 0; k < n_kij; k++) push(ins(k > 0, 0, 1, pix(o, k), 1, 0, 7'b0), 0, 0, 0, 0);
            push(ins(1, 1, 1, 0, 1, 0, 7'b0), 0, 0, 0, 0);
            push(idle, 0, 1, 0, 0);
        end
        push(idle, 0, 0, 1, 0);
    endfunction

    always @(posedge clk) begin : model
        item_t it;
        if (!rst_n) begin
            q.delete();
            e_inst = idle;
            {e_busy, e_clr, e_ov, e_dn} = 4'b0;
        end else begin
            if (q.size() == 0 && bus.start) build();
            if (q.size() == 0 || (q[0].wr && !bus.ofifo_valid)) begin
                e_inst = idle;
                e_busy = q.size() != 0;
                {e_clr, e_ov, e_dn} = 3'b0;
            end else begin
                it = q.pop_front();
                e_inst = it.inst;
                e_clr = it.clr;
                e_ov = it.ov;
                e_dn = it.dn;
                e_busy = !it.dn;
            end
        end
    end

    always @(negedge clk) begin
        chk("inst", bus.inst, e_inst);
        chk("busy", 34'(bus.busy), 34'(e_busy));
        chk("acc_clr", 34'(bus.acc_clr), 34'(e_clr));
        chk("out_valid", 34'(bus.out_valid), 34'(e_ov));
        chk("done", 34'(bus.done), 34'(e_dn));
        if (!bus.inst[32] && !bus.inst[31]) wr_q.push_back(int'(bus.inst[30:20]));
        if (!bus.inst[32] && bus.inst[31]) rd_q.push_back(int'(bus.inst[30:20]));
        if (bus.inst[2] && !bus.inst[19] && bus.inst[17:7] >= 11'd1024) xw_q.push_back(int'(bus.inst[17:7]));
        ov_cnt += int'(bus.out_valid);
        dn_cnt += int'(bus.done);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        xw_q.delete();
        ov_cnt = 0;
        dn_cnt = 0;
    endtask

    task automatic kick();
        bus.start = 1;
        cyc();
        bus.start = 0;
        chk("first_inst", bus.inst, 34'h1_8006_0004);
        chk("first_busy", 34'(bus.busy), 34'd1);
    endtask

    // mode 0: ofifo always valid; 1: random; 2: valid except a fixed 5-cycle gap inside kij=0 DRAIN
    task automatic run(input int mode, output int bcnt);
        bit fin;
        fin = 0;
        bcnt = 1;
        for (int n = 1; n < 6000 && !fin; n++) begin
            cyc();
            if (n < col) chk("wl0_addr", 34'(bus.inst[17:7]), 34'(1024 + n));
            if (bus.busy) bcnt++;
            fin = bus.done;
            bus.start = !fin && bus.busy && $urandom_range(0, 7) == 0;
            bus.ofifo_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : !(n >= 130 && n < 135);
        end
        bus.start = 0;
        chk("done_seen", 34'(fin), 34'd1);
    endtask

    task automatic chk_writes();
        chk("wr_count", 34'(wr_q.size()), 34'd324);
        foreach (wr_q[i]) chk("wr_addr", 34'(wr_q[i]), 34'(i));
        chk("ov_pulses", 34'(ov_cnt), 34'd16);
        chk("done_pulses", 34'(dn_cnt), 34'd1);
    endtask

    initial begin
        int bc;
        bus.start = 0;
        bus.ofifo_valid = 0;
        rst_n = 0;
        repeat (3) cyc();
        chk("rst_inst", bus.inst, 34'h1_800C_0000);
        chk("rst_busy", 34'(bus.busy), 34'd0);
        rst_n = 1;
        cyc();
        bus.ofifo_valid = 1;
        clear_mon();
        kick();
        run(0, bc);
        chk("busy_cycles", 34'(bc), 34'd1632);
        chk_writes();
        chk("rd_count", 34'(rd_q.size()), 34'd144);
        chk("rd_o0k0", 34'(rd_q[0]), 34'd0);
        chk("rd_o5k4", 34'(rd_q[49]), 34'd158);
        chk("rd_o15k8", 34'(rd_q[143]), 34'd323);
        chk("xw_count", 34'(xw_q.size()), 34'd72);
        chk("xw_k8_first", 34'(xw_q[64]), 34'd1088);
        chk("xw_k8_last", 34'(xw_q[71]), 34'd1095);
        repeat (3) cyc();
        clear_mon();
        kick();
        run(2, bc);
        chk("stall_busy_cycles", 34'(bc), 34'd1637);
        chk_writes();
        repeat (2) cyc();
        kick();
        repeat (80) begin
            cyc();
            bus.ofifo_valid = 1'($urandom_range(0, 1));
        end
        rst_n = 0;
        bus.start = 1;
        #1;
        chk("rst_mid_inst", bus.inst, 34'h1_800C_0000);
        chk("rst_mid_busy", 34'(bus.busy), 34'd0);
        repeat (2) cyc();
        bus.start = 0;
        rst_n = 1;
        cyc();
        chk("post_rst_inst", bus.inst, 34'h1_800C_0000);
        chk("post_rst_busy", 34'(bus.busy), 34'd0);
        clear_mon();
        kick();
        run(1, bc);
        chk_writes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
